cp_fifo_fetch: RTL and testbench

CP_FIFO_FETCH -- requirements
Module: cp_fifo_fetch

---
 rtl/cp_fifo_fetch.sv | 192 +++++++++++++++++++
 tb/tb_cp_fifo_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp_fifo_fetch.sv
// Command-FIFO fetch engine: pulls 32-byte lines from a ring buffer over AXI and streams 128-bit beats to the decoder.
// Optional watermark interrupts are built only when CP_FIFO_WATERMARK_EN is defined.
module cp_fifo_fetch #(
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         fifo_en,
  input  logic [31:0]  fifo_base,
  input  logic [31:0]  fifo_end,
  input  logic [31:0]  fifo_wrptr,
  input  logic         rdptr_load,
  input  logic [31:0]  rdptr_load_val,
  output logic [31:0]  fifo_rdptr,
  output logic [31:0]  fifo_count,
  output logic [31:0]  araddrm_a,
  output logic [1:0]   arburstm_a,
  output logic [3:0]   arlenm_a,
  output logic [2:0]   arsizem_a,
  output logic         arvalidm_a,
  input  logic         arreadym_a,
  input  logic [127:0] rdatam_a,
  input  logic [1:0]   rrespm_a,
  input  logic         rlastm_a,
  input  logic         rvalidm_a,
  output logic         rreadym_a,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err_sticky,
  output logic         irq_hi,
  output logic         irq_lo,
  input  logic [31:0]  fifo_hi_wm,
  input  logic [31:0]  fifo_lo_wm
);

  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(BUF_DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(BUF_DEPTH);
  localparam logic [31:0] LINE_BYTES = 32'd32;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t state, state_n;

  logic [31:0]   rdptr_q;
  logic [127:0]  mem [BUF_DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;
  logic [AW:0]   occ;
  logic [1:0]    inflight;
  logic          push, pop;
  logic          load_take, start, burst_done, room;
  logic [AW+1:0] free_slots, need_slots;
  logic [31:0]   ring_bytes;
  logic          err_q;

  // Pending bytes between read and write pointer, accounting for ring wrap.
  always_comb begin
    ring_bytes = fifo_end + LINE_BYTES - fifo_base;
    if (fifo_wrptr >= rdptr_q) begin
      fifo_count = fifo_wrptr - rdptr_q;
    end else begin
      fifo_count = ring_bytes - (rdptr_q - fifo_wrptr);
    end
  end

  // A burst may start only if the whole line fits beside beats already promised.
  always_comb begin
    free_slots = DEPTH_W - {1'b0, occ};
    need_slots = (AW+2)'(inflight) + (AW+2)'(2);
    room       = (free_slots >= need_slots);
  end

  always_comb begin
    state_n    = state;
    start      = 1'b0;
    load_take  = 1'b0;
    burst_done = 1'b0;
    case (state)
      IDLE: begin
        if (rdptr_load) begin
          load_take = 1'b1;
        end else if (fifo_en && (fifo_count != '0) && room) begin
          start   = 1'b1;
          state_n = ADDR;
        end
      end
      ADDR: begin
        if (arreadym_a) begin
          state_n = DATA;
        end
      end
      DATA: begin
        if (rvalidm_a && rlastm_a) begin
          burst_done = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign araddrm_a  = rdptr_q;
  assign arlenm_a   = 4'd1;
  assign arsizem_a  = 3'b100;
  assign arburstm_a = 2'b01;
  assign arvalidm_a = (state == ADDR);
  assign rreadym_a  = (state == DATA);

  assign push      = rreadym_a && rvalidm_a && (occ != FULL_OCC);
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_idx];

  assign fifo_rdptr = rdptr_q;
  assign err_sticky = err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      rdptr_q  <= '0;
      inflight <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_n;
      if (load_take) begin
        rdptr_q <= rdptr_load_val;
      end else if (burst_done) begin
        rdptr_q <= (rdptr_q == fifo_end) ? fifo_base : rdptr_q + LINE_BYTES;
      end
      if (start) begin
        inflight <= 2'd2;
      end else if (push && (inflight != '0)) begin
        inflight <= inflight - 2'd1;
      end
      if (load_take) begin
        err_q <= 1'b0;
      end else if (push && (rrespm_a != 2'b00)) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (pop) begin
        rd_idx <= rd_idx + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Beat storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= rdatam_a;
    end
  end

`ifdef CP_FIFO_WATERMARK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_hi <= 1'b0;
      irq_lo <= 1'b0;
    end else begin
      irq_hi <= (fifo_count > fifo_hi_wm);
      irq_lo <= (fifo_count < fifo_lo_wm);
    end
  end
`else
  logic wm_unused;
  assign wm_unused = ^{fifo_hi_wm, fifo_lo_wm};
  assign irq_hi    = 1'b0;
  assign irq_lo    = 1'b0;
`endif

endmodule

// File: tb/tb_cp_fifo_fetch.sv
// Self-checking bench for cp_fifo_fetch: directed ring scenarios plus randomized traffic
// against a queue-based model of the fetch/stream behaviour.
module tb_cp_fifo_fetch;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         fifo_en;
  logic [31:0]  fifo_base, fifo_end, fifo_wrptr;
  logic         rdptr_load;
  logic [31:0]  rdptr_load_val;
  logic [31:0]  fifo_rdptr, fifo_count;
  logic [31:0]  araddrm_a;
  logic [1:0]   arburstm_a;
  logic [3:0]   arlenm_a;
  logic [2:0]   arsizem_a;
  logic         arvalidm_a, arreadym_a;
  logic [127:0] rdatam_a;
  logic [1:0]   rrespm_a;
  logic         rlastm_a, rvalidm_a, rreadym_a;
  logic [127:0] out_data;
  logic         out_valid, out_ready;
  logic         err_sticky, irq_hi, irq_lo;
  logic [31:0]  fifo_hi_wm, fifo_lo_wm;

  always #5 clk = ~clk;

  cp_fifo_fetch #(.BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .fifo_en(fifo_en),
    .fifo_base(fifo_base), .fifo_end(fifo_end), .fifo_wrptr(fifo_wrptr),
    .rdptr_load(rdptr_load), .rdptr_load_val(rdptr_load_val),
    .fifo_rdptr(fifo_rdptr), .fifo_count(fifo_count),
    .araddrm_a(araddrm_a), .arburstm_a(arburstm_a), .arlenm_a(arlenm_a),
    .arsizem_a(arsizem_a), .arvalidm_a(arvalidm_a), .arreadym_a(arreadym_a),
    .rdatam_a(rdatam_a), .rrespm_a(rrespm_a), .rlastm_a(rlastm_a),
    .rvalidm_a(rvalidm_a), .rreadym_a(rreadym_a),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_sticky(err_sticky), .irq_hi(irq_hi), .irq_lo(irq_lo),
    .fifo_hi_wm(fifo_hi_wm), .fifo_lo_wm(fifo_lo_wm)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Stimulus policy
  logic        s_en, s_load, s_out_ready, s_rand_resp, s_drop_b0;
  logic [31:0] s_base, s_end, s_wr, s_load_val, s_hi, s_lo;
  logic [1:0]  s_resp1;
  int          s_ar_pct, s_rv_pct;

  // Behavioural model
  logic         m_req, m_burst, m_err, m_irq_hi, m_irq_lo;
  int           m_beat;
  logic [31:0]  m_rdptr, m_addr;
  logic [127:0] q[$];
  logic [31:0]  ar_log[$];
  logic [127:0] pop_log[$];

`ifdef CP_FIFO_WATERMARK_EN
  localparam logic WM_ON = 1'b1;
`else
  localparam logic WM_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [127:0] beat_data(input logic [31:0] a, input int b);
    return {a, ~a, a ^ 32'h5A5A_C3C3, 32'(b) ^ 32'hBEEF_0000};
  endfunction

  function automatic logic [31:0] model_count();
    logic [31:0] ring;
    ring = s_end + 32'd32 - s_base;
    if (s_wr >= m_rdptr) return s_wr - m_rdptr;
    return ring - (m_rdptr - s_wr);
  endfunction

  task automatic model_reset();
    m_req = 1'b0; m_burst = 1'b0; m_err = 1'b0; m_beat = 0;
    m_irq_hi = 1'b0; m_irq_lo = 1'b0; m_rdptr = '0; m_addr = '0;
    q.delete();
  endtask

  // One clock: check registered outputs, drive inputs, predict the next edge.
  task automatic step();
    logic [31:0]  cnt;
    logic         push;
    logic [127:0] pd;
    @(negedge clk);
    chk("arvalid", 32'(arvalidm_a), 32'(m_req));
    chk("rready", 32'(rreadym_a), 32'(m_burst));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("rdptr", fifo_rdptr, m_rdptr);
    chk("err_sticky", 32'(err_sticky), 32'(m_err));
    chk("irq_hi", 32'(irq_hi), 32'(m_irq_hi));
    chk("irq_lo", 32'(irq_lo), 32'(m_irq_lo));
    resetn = 1'b1;
    if (s_drop_b0 && m_burst && m_beat == 0) s_en = 1'b0;
    fifo_en = s_en; fifo_base = s_base; fifo_end = s_end; fifo_wrptr = s_wr;
    rdptr_load = s_load; rdptr_load_val = s_load_val;
    fifo_hi_wm = s_hi; fifo_lo_wm = s_lo;
    out_ready = s_out_ready;
    arreadym_a = ($urandom_range(99) < s_ar_pct);
    rvalidm_a = m_burst && (($urandom_range(99) < s_rv_pct) || (s_drop_b0 && m_beat == 0));
    rdatam_a = beat_data(m_addr, m_beat);
    rlastm_a = m_burst && (m_beat == 1);
    rrespm_a = (m_beat == 1) ? s_resp1 : 2'b00;
    if (s_rand_resp && $urandom_range(9) == 0) rrespm_a = 2'($urandom_range(3, 1));
    #1;
    cnt = model_count();
    chk("fifo_count", fifo_count, cnt);
    push = 1'b0;
    pd = '0;
    if (m_req) begin
      if (arreadym_a) begin
        chk("araddr", araddrm_a, m_rdptr);
        chk("arlen", 32'(arlenm_a), 32'd1);
        chk("arsize", 32'(arsizem_a), 32'd4);
        chk("arburst", 32'(arburstm_a), 32'd1);
        ar_log.push_back(araddrm_a);
        m_addr = m_rdptr; m_req = 1'b0; m_burst = 1'b1; m_beat = 0;
      end
    end else if (m_burst) begin
      if (rvalidm_a) begin
        push = 1'b1;
        pd = beat_data(m_addr, m_beat);
        if (rrespm_a != 2'b00) m_err = 1'b1;
        if (m_beat == 1) begin
          m_burst = 1'b0;
          m_rdptr = (m_rdptr == s_end) ? s_base : m_rdptr + 32'd32;
        end
        m_beat++;
      end
    end else begin
      if (s_load) begin
        m_rdptr = s_load_val;
        m_err = 1'b0;
      end else if (s_en && cnt != 0 && (int'(DEPTH) - q.size()) >= 2) begin
        m_req = 1'b1;
      end
    end
    if (q.size() != 0 && out_ready) begin
      chk_w("out_data", out_data, q[0]);
      pop_log.push_back(out_data);
      void'(q.pop_front());
    end
    if (push) q.push_back(pd);
    if (WM_ON) begin
      m_irq_hi = (cnt > s_hi);
      m_irq_lo = (cnt < s_lo);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_ptr(input logic [31:0] v);
    s_load = 1'b1; s_load_val = v;
    step();
    s_load = 1'b0;
  endtask

  task automatic reset_pulse();
    #1;
    resetn = 1'b0;
    rvalidm_a = 1'b0;
    #1;
    chk("rst arvalid", 32'(arvalidm_a), 32'd0);
    chk("rst rready", 32'(rreadym_a), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst err", 32'(err_sticky), 32'd0);
    chk("rst irq", 32'({irq_hi, irq_lo}), 32'd0);
    chk("rst rdptr", fifo_rdptr, 32'd0);
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    resetn = 1'b0; fifo_en = 0; fifo_base = '0; fifo_end = '0; fifo_wrptr = '0;
    rdptr_load = 0; rdptr_load_val = '0; arreadym_a = 0; rdatam_a = '0;
    rrespm_a = '0; rlastm_a = 0; rvalidm_a = 0; out_ready = 0;
    fifo_hi_wm = '0; fifo_lo_wm = '0;
    s_en = 0; s_load = 0; s_out_ready = 1; s_rand_resp = 0; s_drop_b0 = 0;
    s_base = 32'h1000; s_end = 32'h10E0; s_wr = 32'h1040; s_load_val = '0;
    s_hi = 32'hFFFF_FFFF; s_lo = '0; s_resp1 = 2'b00; s_ar_pct = 100; s_rv_pct = 100;
    model_reset();
    #12;
    chk("init arvalid", 32'(arvalidm_a), 32'd0);
    chk("init out_valid", 32'(out_valid), 32'd0);
    chk("init rdptr", fifo_rdptr, 32'd0);
    chk("init err", 32'(err_sticky), 32'd0);

    // Two lines, no wrap
    load_ptr(32'h1000);
    chk("s1 count pre", fifo_count, 32'h40);
    ar_log.delete(); pop_log.delete();
    s_en = 1;
    repeat (30) step();
    chk("s1 bursts", 32'(ar_log.size()), 32'd2);
    if (ar_log.size() == 2) begin
      chk("s1 addr0", ar_log[0], 32'h1000);
      chk("s1 addr1", ar_log[1], 32'h1020);
    end
    chk("s1 beats", 32'(pop_log.size()), 32'd4);
    if (pop_log.size() == 4) begin
      chk_w("s1 beat0", pop_log[0], beat_data(32'h1000, 0));
      chk_w("s1 beat3", pop_log[3], beat_data(32'h1020, 1));
    end
    chk("s1 rdptr", fifo_rdptr, 32'h1040);
    chk("s1 count", fifo_count, 32'h0);

    // Wrap from ring end back to base
    s_en = 0; s_wr = 32'h1020;
    load_ptr(32'h10E0);
    chk("s2 count pre", fifo_count, 32'h40);
    ar_log.delete();
    s_en = 1;
    repeat (30) step();
    chk("s2 bursts", 32'(ar_log.size()), 32'd2);
    if (ar_log.size() == 2) begin
      chk("s2 addr0", ar_log[0], 32'h10E0);
      chk("s2 addr1", ar_log[1], 32'h1000);
    end
    chk("s2 rdptr", fifo_rdptr, 32'h1020);

    // Back-pressure: buffer fills, then needs two free slots
    s_out_ready = 0; s_wr = 32'h10C0; ar_log.delete();
    repeat (30) step();
    chk("s3 bursts full", 32'(ar_log.size()), 32'd2);
    chk("s3 arvalid idle", 32'(arvalidm_a), 32'd0);
    s_out_ready = 1; step(); s_out_ready = 0;
    repeat (8) step();
    chk("s3 one pop", 32'(ar_log.size()), 32'd2);
    s_out_ready = 1; step(); s_out_ready = 0;
    repeat (8) step();
    chk("s3 two pops", 32'(ar_log.size()), 32'd3);
    s_out_ready = 1;
    repeat (30) step();
    s_en = 0;
    repeat (10) step();

    // Enable dropped during first data beat
    s_wr = 32'h1080;
    load_ptr(32'h1000);
    ar_log.delete(); s_drop_b0 = 1; s_en = 1;
    repeat (20) step();
    s_drop_b0 = 0;
    chk("s4 bursts", 32'(ar_log.size()), 32'd1);
    chk("s4 rdptr", fifo_rdptr, 32'h1020);
    chk("s4 arvalid", 32'(arvalidm_a), 32'd0);

    // Error response on beat 1
    s_en = 0; s_wr = 32'h1020; s_resp1 = 2'b10;
    load_ptr(32'h1000);
    pop_log.delete(); s_en = 1;
    repeat (15) step();
    chk("s5 err", 32'(err_sticky), 32'd1);
    chk("s5 beats", 32'(pop_log.size()), 32'd2);
    if (pop_log.size() == 2) chk_w("s5 err beat", pop_log[1], beat_data(32'h1000, 1));
    s_en = 0; s_resp1 = 2'b00;
    load_ptr(32'h1000);
    chk("s5 err cleared", 32'(err_sticky), 32'd0);

    // Reset while a request waits in ADDR with data buffered
    s_wr = 32'h1060; s_out_ready = 0; s_en = 1;
    guard = 0;
    while (q.size() < 2 && guard < 20) begin step(); guard++; end
    s_ar_pct = 0;
    guard = 0;
    while (!m_req && guard < 20) begin step(); guard++; end
    chk("s6 reached ADDR", 32'(arvalidm_a), 32'd1);
    reset_pulse();
    s_en = 0; s_ar_pct = 100; s_out_ready = 1;
    step();

    // Watermarks
    s_wr = 32'h1040; s_hi = 32'h20; s_lo = 32'h0;
    load_ptr(32'h1000);
    step();
    chk("wm irq_hi", 32'(irq_hi), 32'(WM_ON));
    s_hi = 32'h40; s_lo = 32'h41;
    step();
    chk("wm irq_hi eq", 32'(irq_hi), 32'd0);
    chk("wm irq_lo", 32'(irq_lo), 32'(WM_ON));

    // Randomized traffic over an eight-line ring
    s_base = 32'h2000; s_end = 32'h20E0; s_wr = 32'h2080;
    repeat (10) step();
    load_ptr(32'h2000);
    s_rand_resp = 1;
    for (int i = 0; i < 800; i++) begin
      s_en = ($urandom_range(99) < 80);
      s_out_ready = ($urandom_range(99) < 60);
      s_ar_pct = 70; s_rv_pct = 70;
      if ($urandom_range(9) == 0) s_wr = 32'h2000 + 32'd32 * $urandom_range(7);
      s_load = ($urandom_range(99) < 3);
      s_load_val = 32'h2000 + 32'd32 * $urandom_range(7);
      s_hi = 32'd32 * $urandom_range(8);
      s_lo = 32'd32 * $urandom_range(8);
      step();
    end
    s_load = 0; s_rand_resp = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
